next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Parametrised successor to the single-cycle next-address selector.
- Owns the fetch PC register of the pipelined core.
- Resolves all RV32I control-flow types reported by the EX stage: beq, bne, blt, bge, bltu, bgeu, jal, jalr.
- Redirects fetch and flushes the front end on a misprediction. Optionally predicts taken branches at fetch with a small BTB.
- Sits between the IF stage (PC out) and EX stage (resolution in). Word-addressed: sequential next PC is PC+1.

Parameters:
ADDR_W, 32, PC/address width in bits (word address)
RESET_ADDR, 0, PC value loaded by reset
BTB_DEPTH, 16, BTB entry count, power of two, >=2 (used only with BTB_EN)

Ports:
clk  in  1  core clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
stall_i  in  1  IF stall from hazard unit; holds PC when no redirect
br_valid_i  in  1  EX holds a resolved control-flow instruction this cycle (one-cycle pulse per instruction)
br_type_i  in  4  0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL, 8 JALR; 9-15 treated as NONE
zero_i  in  1  ALU equal flag
less_i  in  1  ALU signed-less flag
lessu_i  in  1  ALU unsigned-less flag
ex_pc_i  in  ADDR_W  PC of the EX instruction
pc_rel_addr_i  in  ADDR_W  ex_pc + offset (branch/jal target)
reg_rel_addr_i  in  ADDR_W  rs1 + imm (jalr target)
ex_pred_taken_i  in  1  prediction bit carried down the pipe with the EX instruction
pc_o  out  ADDR_W  current fetch PC
pc_valid_o  out  1  pc_o is a fetchable address
pred_taken_o  out  1  fetch-time prediction for pc_o, piped down by IF/ID
flush_o  out  1  combinational; kill IF/ID and ID/EX contents this cycle

Behaviour:
- Reset, asynchronous: pc_o=RESET_ADDR, pc_valid_o=0, all BTB valid bits cleared. First clock after release sets pc_valid_o=1; pc_o holds RESET_ADDR for that edge. Reset mid-operation discards any redirect in flight.
- Actual outcome taken:
  - BEQ: zero_i. BNE: !zero_i.
  - BLT: less_i. BGE: !less_i.
  - BLTU: lessu_i. BGEU: !lessu_i.
  - JAL, JALR: 1. NONE: 0.
- Actual target: reg_rel_addr_i for JALR, else pc_rel_addr_i.
- Mispredict when br_valid_i and one of:
  - taken != ex_pred_taken_i, or
  - type is JALR (JALR is never predicted).
- Redirect address: actual target if taken, else ex_pc_i+1. Addition wraps modulo 2^ADDR_W.
- Next-PC priority, highest first:
  - !pc_valid_o -> hold
  - mispredict -> redirect address, flush_o=1
  - stall_i -> hold
  - pred_taken_o -> BTB target
  - else pc_o+1
- A redirect overrides stall_i in the same cycle. flush_o=0 whenever br_valid_i=0.
- Latency: redirect PC visible on pc_o one cycle after br_valid_i.

Optional Feature:
- NEXT_PC_BTB_EN defined:
  - Direct-mapped BTB of BTB_DEPTH entries. Each entry: valid, tag (upper PC bits), target, 2-bit saturating counter.
  - Lookup is combinational on pc_o. pred_taken_o = hit and counter>=2.
  - Update on br_valid_i for conditional branches and JAL only, at ex_pc_i index:
    - hit: counter +1 if taken, -1 if not, saturating at 0 and 3; target rewritten.
    - miss and taken: allocate with counter=2.
    - miss and not taken: no change.
  - A same-cycle update and lookup at the same index uses the old entry (no bypass).
- NEXT_PC_BTB_EN undefined: no BTB storage. pred_taken_o tied 0 (static not-taken). Every taken branch or jump mispredicts.

Decomposition:
- Shared package next_pc_pkg holds: br_type encodings, counter constants (WEAK_TAKEN=2, MAX=3), and the br_taken function.
- One sub-module, btb, instantiated only under NEXT_PC_BTB_EN.

Test Plan:
- Reset release with RESET_ADDR=0x100: pc_valid_o 0 then 1. pc_o sequence 0x100, 0x100, 0x101, 0x102.
- BEQ at ex_pc 0x10, zero_i=1, pred 0, target 0x20: flush_o=1 that cycle, pc_o=0x20 next. With zero_i=0: no flush, sequential PC.
- JALR with stall_i=1, reg_rel 0x3FC: flush_o=1 and pc_o=0x3FC next (redirect beats stall). Stall alone holds pc_o.
- BGEU vs BGE with less_i=1, lessu_i=0: BGEU taken, BGE not. BLTU at pc 0xFFFFFFFF, not taken, pred 1: pc_o=0x0 (wrap).
- BTB_EN: BNE at 0x40 -> 0x80 taken twice. Third fetch of 0x40 gives pred_taken_o=1 and pc_o=0x80 next cycle. Resolve not-taken -> flush, pc_o=0x41.
- Type 12 with br_valid_i=1: no flush, no BTB update, PC sequential.

Source files
------------

// File: rtl/next_pc_pkg.sv
// Shared definitions for the next-PC unit: control-flow type encodings,
// BTB counter constants and the branch-outcome helpers.
package next_pc_pkg;

    localparam int unsigned BR_TYPE_W = 4;
    localparam int unsigned CTR_W     = 2;

    typedef enum logic [BR_TYPE_W-1:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    localparam logic [CTR_W-1:0] CTR_MIN        = 2'd0;
    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = 2'd2;
    localparam logic [CTR_W-1:0] CTR_MAX        = 2'd3;

    // Actual outcome of a resolved instruction; unknown encodings behave as NONE.
    function automatic logic br_taken(input logic [BR_TYPE_W-1:0] br_type,
                                      input logic zero,
                                      input logic less,
                                      input logic lessu);
        logic taken;
        case (br_type)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = !zero;
            BR_BLT:  taken = less;
            BR_BGE:  taken = !less;
            BR_BLTU: taken = lessu;
            BR_BGEU: taken = !lessu;
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Conditional branches and JAL train the BTB; JALR targets are not cached.
    function automatic logic br_trains_btb(input logic [BR_TYPE_W-1:0] br_type);
        logic trains;
        case (br_type)
            BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL: trains = 1'b1;
            default: trains = 1'b0;
        endcase
        return trains;
    endfunction

    function automatic logic [CTR_W-1:0] ctr_update(input logic [CTR_W-1:0] ctr,
                                                    input logic taken);
        logic [CTR_W-1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_MAX) ? ctr : ctr + CTR_W'(1);
        end else begin
            nxt = (ctr == CTR_MIN) ? ctr : ctr - CTR_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/next_pc_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// training from EX-stage resolutions. Old entry is seen on same-index update.
module next_pc_unit_btb
    import next_pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_en_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];
    logic [CTR_W-1:0]  ctr_q    [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             wr_en;
    logic [CTR_W-1:0] wr_ctr;

    // Lookup
    always_comb begin
        lk_idx        = lookup_pc_i[IDX_W-1:0];
        lk_tag        = lookup_pc_i[ADDR_W-1:IDX_W];
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = lk_hit && (ctr_q[lk_idx] >= CTR_WEAK_TAKEN);
        pred_target_o = target_q[lk_idx];
    end

    // Update: train on hit, allocate only on a taken miss
    always_comb begin
        up_idx = upd_pc_i[IDX_W-1:0];
        up_tag = upd_pc_i[ADDR_W-1:IDX_W];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        wr_en  = upd_en_i && (up_hit || upd_taken_i);
        wr_ctr = up_hit ? ctr_update(ctr_q[up_idx], upd_taken_i) : CTR_WEAK_TAKEN;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target_i;
            ctr_q[up_idx]    <= wr_ctr;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with EX-stage branch resolution, redirect and flush.
// Define NEXT_PC_BTB_EN to add a direct-mapped BTB for fetch-time prediction.
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
    parameter int unsigned        BTB_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 stall_i,
    input  logic                 br_valid_i,
    input  logic [BR_TYPE_W-1:0] br_type_i,
    input  logic                 zero_i,
    input  logic                 less_i,
    input  logic                 lessu_i,
    input  logic [ADDR_W-1:0]    ex_pc_i,
    input  logic [ADDR_W-1:0]    pc_rel_addr_i,
    input  logic [ADDR_W-1:0]    reg_rel_addr_i,
    input  logic                 ex_pred_taken_i,
    output logic [ADDR_W-1:0]    pc_o,
    output logic                 pc_valid_o,
    output logic                 pred_taken_o,
    output logic                 flush_o
);

    if (BTB_DEPTH < 2 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0
        || $clog2(BTB_DEPTH) >= ADDR_W) begin : g_bad_btb_depth
        $error("next_pc_unit: BTB_DEPTH must be a power of two, >= 2 and narrower than ADDR_W");
    end

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;

    logic              taken_c;
    logic              is_jalr_c;
    logic              mispredict_c;
    logic [ADDR_W-1:0] target_c;
    logic [ADDR_W-1:0] redirect_c;
    logic              pred_taken_c;
    logic [ADDR_W-1:0] pred_target_c;

    // Resolve the EX instruction against the prediction it carried
    always_comb begin
        taken_c      = br_taken(br_type_i, zero_i, less_i, lessu_i);
        is_jalr_c    = (br_type_i == BR_JALR);
        target_c     = is_jalr_c ? reg_rel_addr_i : pc_rel_addr_i;
        mispredict_c = br_valid_i && ((taken_c != ex_pred_taken_i) || is_jalr_c);
        redirect_c   = taken_c ? target_c : ex_pc_i + ADDR_W'(1);
    end

`ifdef NEXT_PC_BTB_EN
    logic btb_upd_en;

    assign btb_upd_en = br_valid_i && br_trains_btb(br_type_i);

    next_pc_unit_btb #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BTB_DEPTH)
    ) u_btb (
        .clk           (clk),
        .rstn          (rstn),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (pred_taken_c),
        .pred_target_o (pred_target_c),
        .upd_en_i      (btb_upd_en),
        .upd_taken_i   (taken_c),
        .upd_pc_i      (ex_pc_i),
        .upd_target_i  (target_c)
    );
`else
    // Static not-taken: every taken control transfer redirects from EX.
    assign pred_taken_c  = 1'b0;
    assign pred_target_c = '0;
`endif

    // Next-PC selection, highest priority first
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        if (!pc_valid_q) begin
            pc_d = pc_q;
        end else if (mispredict_c) begin
            pc_d = redirect_c;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pred_taken_c) begin
            pc_d = pred_target_c;
        end else begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= RESET_ADDR;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign pc_o         = pc_q;
    assign pc_valid_o   = pc_valid_q;
    assign pred_taken_o = pred_taken_c;
    assign flush_o      = pc_valid_q && mispredict_c;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed vector bench for next_pc_unit; BTB sequences run when
// NEXT_PC_BTB_EN is defined for the build.
module tb_next_pc_unit;
    import next_pc_pkg::*;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          stall_i = 1'b0;
    logic          br_valid_i = 1'b0;
    logic [3:0]    br_type_i = 4'd0;
    logic          zero_i = 1'b0;
    logic          less_i = 1'b0;
    logic          lessu_i = 1'b0;
    logic [AW-1:0] ex_pc_i = '0;
    logic [AW-1:0] pc_rel_addr_i = '0;
    logic [AW-1:0] reg_rel_addr_i = '0;
    logic          ex_pred_taken_i = 1'b0;
    logic [AW-1:0] pc_o;
    logic          pc_valid_o;
    logic          pred_taken_o;
    logic          flush_o;

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] model_pc;

    always #5 clk = ~clk;

    next_pc_unit #(
        .ADDR_W     (AW),
        .RESET_ADDR (32'h100),
        .BTB_DEPTH  (16)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .stall_i         (stall_i),
        .br_valid_i      (br_valid_i),
        .br_type_i       (br_type_i),
        .zero_i          (zero_i),
        .less_i          (less_i),
        .lessu_i         (lessu_i),
        .ex_pc_i         (ex_pc_i),
        .pc_rel_addr_i   (pc_rel_addr_i),
        .reg_rel_addr_i  (reg_rel_addr_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .pred_taken_o    (pred_taken_o),
        .flush_o         (flush_o)
    );

    typedef struct {
        string         name;
        logic          valid;
        logic [3:0]    bt;
        logic          zero;
        logic          less;
        logic          lessu;
        logic          stall;
        logic          pred;
        logic [AW-1:0] ex_pc;
        logic [AW-1:0] pc_rel;
        logic [AW-1:0] reg_rel;
        logic          exp_pred;
        logic          exp_flush;
        logic          abs_pc;
        logic [AW-1:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic valid, input logic [3:0] bt,
                                input logic zero, input logic less, input logic lessu,
                                input logic stall, input logic pred,
                                input logic [AW-1:0] ex_pc, input logic [AW-1:0] pc_rel,
                                input logic [AW-1:0] reg_rel, input logic exp_pred,
                                input logic exp_flush, input logic abs_pc,
                                input logic [AW-1:0] exp_pc);
        vec_t v;
        v.name = name; v.valid = valid; v.bt = bt;
        v.zero = zero; v.less = less; v.lessu = lessu;
        v.stall = stall; v.pred = pred;
        v.ex_pc = ex_pc; v.pc_rel = pc_rel; v.reg_rel = reg_rel;
        v.exp_pred = exp_pred; v.exp_flush = exp_flush;
        v.abs_pc = abs_pc; v.exp_pc = exp_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of EX inputs, check combinational outputs, then the next PC.
    task automatic apply(input vec_t v);
        @(negedge clk);
        br_valid_i      = v.valid;
        br_type_i       = v.bt;
        zero_i          = v.zero;
        less_i          = v.less;
        lessu_i         = v.lessu;
        stall_i         = v.stall;
        ex_pred_taken_i = v.pred;
        ex_pc_i         = v.ex_pc;
        pc_rel_addr_i   = v.pc_rel;
        reg_rel_addr_i  = v.reg_rel;
        #1;
        check({v.name, " flush"}, AW'(flush_o), AW'(v.exp_flush));
        check({v.name, " pred"}, AW'(pred_taken_o), AW'(v.exp_pred));
        if (v.abs_pc || v.exp_flush) model_pc = v.exp_pc;
        else if (!v.stall)           model_pc = model_pc + AW'(1);
        @(posedge clk);
        #1;
        check({v.name, " pc"}, pc_o, model_pc);
    endtask

    task automatic idle();
        @(negedge clk);
        br_valid_i = 1'b0;
        stall_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //      name        vld type     z  l  lu st pr ex_pc         pc_rel        reg_rel      ep ef abs exp_pc
        vecs.push_back(mk("beq_t",   1, BR_BEQ,  1, 0, 0, 0, 0, 32'h10,       32'h20,  32'h0,   0, 1, 0, 32'h20));
        vecs.push_back(mk("beq_nt",  1, BR_BEQ,  0, 0, 0, 0, 0, 32'h10,       32'h20,  32'h0,   0, 0, 0, 32'h0));
        vecs.push_back(mk("jalr_st", 1, BR_JALR, 0, 0, 0, 1, 0, 32'h22,       32'h0,   32'h3FC, 0, 1, 0, 32'h3FC));
        vecs.push_back(mk("stall",   0, BR_NONE, 0, 0, 0, 1, 0, 32'h0,        32'h0,   32'h0,   0, 0, 0, 32'h0));
        vecs.push_back(mk("bgeu_t",  1, BR_BGEU, 0, 1, 0, 0, 0, 32'h200,      32'h300, 32'h0,   0, 1, 0, 32'h300));
        vecs.push_back(mk("bge_nt",  1, BR_BGE,  0, 1, 0, 0, 0, 32'h300,      32'h50,  32'h0,   0, 0, 0, 32'h0));
        vecs.push_back(mk("bltu_wr", 1, BR_BLTU, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'h5,   32'h0,   0, 1, 0, 32'h0));
        vecs.push_back(mk("type12",  1, 4'd12,   1, 1, 1, 0, 0, 32'h0,        32'h77,  32'h88,  0, 0, 0, 32'h0));
        vecs.push_back(mk("bne_ok",  1, BR_BNE,  0, 0, 0, 0, 1, 32'h1,        32'h600, 32'h0,   0, 0, 0, 32'h0));
        vecs.push_back(mk("jal_mp",  1, BR_JAL,  0, 0, 0, 0, 0, 32'h2,        32'h700, 32'h0,   0, 1, 0, 32'h700));
        vecs.push_back(mk("jal_ok",  1, BR_JAL,  0, 0, 0, 0, 1, 32'h700,      32'h10,  32'h0,   0, 0, 0, 32'h0));
        vecs.push_back(mk("blt_t",   1, BR_BLT,  0, 1, 0, 0, 0, 32'h701,      32'h800, 32'h0,   0, 1, 0, 32'h800));
        vecs.push_back(mk("beq_mpn", 1, BR_BEQ,  0, 0, 0, 0, 1, 32'h800,      32'h900, 32'h0,   0, 1, 0, 32'h801));
        vecs.push_back(mk("jalr_pr", 1, BR_JALR, 0, 0, 0, 0, 1, 32'h801,      32'h0,   32'h123, 0, 1, 0, 32'h123));
        vecs.push_back(mk("novalid", 0, BR_BEQ,  1, 0, 0, 0, 0, 32'h40,       32'h99,  32'h0,   0, 0, 0, 32'h0));
        vecs.push_back(mk("bne_nt",  1, BR_BNE,  1, 0, 0, 0, 0, 32'h124,      32'h500, 32'h0,   0, 0, 0, 32'h0));

        // Reset release: valid low under reset, PC held for the first edge
        #12;
        check("rst pc", pc_o, 32'h100);
        check("rst valid", AW'(pc_valid_o), AW'(1'b0));
        check("rst flush", AW'(flush_o), AW'(1'b0));
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rel valid", AW'(pc_valid_o), AW'(1'b1));
        check("rel pc0", pc_o, 32'h100);
        @(posedge clk); #1;
        check("rel pc1", pc_o, 32'h101);
        @(posedge clk); #1;
        check("rel pc2", pc_o, 32'h102);
        model_pc = 32'h102;

        foreach (vecs[i]) apply(vecs[i]);
        idle();

`ifdef NEXT_PC_BTB_EN
        // Train BNE at 0x40 -> 0x80, then predict from fetch, then mispredict not-taken
        apply(mk("btb_j1",  1, BR_JALR, 0, 0, 0, 0, 0, model_pc, 32'h0,  32'h40, 0, 1, 1, 32'h40));
        apply(mk("btb_t1",  1, BR_BNE,  0, 0, 0, 0, 0, 32'h40,   32'h80, 32'h0,  0, 1, 1, 32'h80));
        apply(mk("btb_j2",  1, BR_JALR, 0, 0, 0, 0, 0, 32'h80,   32'h0,  32'h40, 0, 1, 1, 32'h40));
        apply(mk("btb_t2",  1, BR_BNE,  0, 0, 0, 0, 1, 32'h40,   32'h80, 32'h0,  1, 0, 1, 32'h80));
        apply(mk("btb_j3",  1, BR_JALR, 0, 0, 0, 0, 0, 32'h80,   32'h0,  32'h40, 0, 1, 1, 32'h40));
        apply(mk("btb_prd", 0, BR_NONE, 0, 0, 0, 0, 0, 32'h0,    32'h0,  32'h0,  1, 0, 1, 32'h80));
        apply(mk("btb_nt",  1, BR_BNE,  1, 0, 0, 0, 1, 32'h40,   32'h80, 32'h0,  0, 1, 1, 32'h41));
        // Counter dropped to 2: still predicts; type 12 at the same PC must not train
        apply(mk("btb_j4",  1, BR_JALR, 0, 0, 0, 0, 0, 32'h41,   32'h0,  32'h40, 0, 1, 1, 32'h40));
        apply(mk("btb_t12", 1, 4'd12,   1, 1, 1, 0, 0, 32'h40,   32'h0,  32'h0,  1, 0, 1, 32'h80));
        apply(mk("btb_j5",  1, BR_JALR, 0, 0, 0, 0, 0, 32'h80,   32'h0,  32'h40, 0, 1, 1, 32'h40));
        apply(mk("btb_prd2",0, BR_NONE, 0, 0, 0, 0, 0, 32'h0,    32'h0,  32'h0,  1, 0, 1, 32'h80));
        idle();
`endif

        // Reset mid-operation discards a redirect in flight
        @(negedge clk);
        br_valid_i      = 1'b1;
        br_type_i       = BR_JAL;
        ex_pred_taken_i = 1'b0;
        ex_pc_i         = 32'h55;
        pc_rel_addr_i   = 32'h999;
        #1;
        check("mid flush", AW'(flush_o), AW'(1'b1));
        rstn = 1'b0;
        #1;
        check("mid rst pc", pc_o, 32'h100);
        check("mid rst valid", AW'(pc_valid_o), AW'(1'b0));
        @(posedge clk); #1;
        check("mid hold pc", pc_o, 32'h100);
        @(negedge clk);
        br_valid_i = 1'b0;
        rstn       = 1'b1;
        @(posedge clk); #1;
        check("mid rel valid", AW'(pc_valid_o), AW'(1'b1));
        check("mid rel pc", pc_o, 32'h100);
        @(posedge clk); #1;
        check("mid seq pc", pc_o, 32'h101);
        check("mid pred", AW'(pred_taken_o), AW'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
